// File: rtl/dcsk_demodulator_if.sv
// Chip-stream / decision bundle between frame sync and the DCSK demodulator.
// master drives chips and reads decisions; slave is the demodulator.
interface dcsk_demodulator_if;
  logic              i_chip;
  logic              i_chip_valid;
  logic              i_sync;
  logic [1:0]        i_sf;
  logic              o_msg_bit;
  logic              o_msg_valid;
  logic signed [5:0] o_corr;
  logic              o_tie;
  logic              o_abort;
  logic              o_busy;

  modport master (
    output i_chip, i_chip_valid, i_sync, i_sf,
    input  o_msg_bit, o_msg_valid, o_corr, o_tie, o_abort, o_busy
  );

  modport slave (
    input  i_chip, i_chip_valid, i_sync, i_sf,
    output o_msg_bit, o_msg_valid, o_corr, o_tie, o_abort, o_busy
  );
endinterface

// File: rtl/dcsk_demodulator.sv
// DCSK receiver: buffers the reference half of each frame, correlates the
// data half against it chip by chip and emits one decided bit per frame.
package spreading_factors_pkg;
  typedef enum logic [1:0] {SF4 = 2'd0, SF8 = 2'd1, SF16 = 2'd2, SF32 = 2'd3} sf_e;

  // Half-frame length H for a 2-bit spreading-factor code.
  function automatic logic [4:0] half_len(input logic [1:0] sf);
    return 5'd2 << sf;
  endfunction
endpackage

module dcsk_demodulator
  import spreading_factors_pkg::*;
(
  input  logic i_clk,
  input  logic i_arst_n,
  dcsk_demodulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REF, DATA} state_e;

  state_e      state, state_d;
  logic [4:0]  cnt, cnt_d;
  logic [4:0]  acc;
  logic [15:0] sr;
  logic [1:0]  sf_q;

  logic              adv, frame_start, mid_sync, last, data_chip, match;
  logic              dec_bit, dec_tie;
  logic [1:0]        sf_cur;
  logic [4:0]        h, tap, idx, a_fin;
  logic signed [6:0] corr_w;

  // A new frame starts on any sync, or implicitly on the chip right after a
  // completed frame (REF with the counter parked at 0).
  always_comb begin
    adv         = bus.i_chip_valid && (state != IDLE || bus.i_sync);
    frame_start = bus.i_chip_valid && (bus.i_sync || (state == REF && cnt == 5'd0));
    mid_sync    = bus.i_chip_valid && bus.i_sync && state != IDLE && cnt != 5'd0;
    sf_cur      = frame_start ? bus.i_sf : sf_q;
    h           = half_len(sf_cur);
    tap         = h - 5'd1;
    idx         = frame_start ? 5'd0 : cnt;
    last        = idx == ({h[3:0], 1'b0} - 5'd1);
    data_chip   = idx >= h;
    match       = data_chip && (bus.i_chip == sr[tap[3:0]]);
    a_fin       = acc + {4'd0, match};
    corr_w      = $signed({1'b0, a_fin, 1'b0}) - $signed({2'b00, h});
  end

  // State register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next state: after the last chip we park in REF with cnt 0 awaiting chip 0.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (adv) begin
      if (last) begin
        state_d = REF;
        cnt_d   = 5'd0;
      end else begin
        cnt_d   = idx + 5'd1;
        state_d = (idx + 5'd1 < h) ? REF : DATA;
      end
    end
  end

  // Output decode
  always_comb begin
    bus.o_busy = state != IDLE;
    dec_bit    = {a_fin, 1'b0} >= {1'b0, h};
    dec_tie    = a_fin == {1'b0, h[4:1]};
  end

  // Datapath and registered outputs
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      sr              <= '0;
      sf_q            <= SF4;
      acc             <= 5'd0;
      bus.o_msg_bit   <= 1'b0;
      bus.o_msg_valid <= 1'b0;
      bus.o_corr      <= '0;
      bus.o_tie       <= 1'b0;
      bus.o_abort     <= 1'b0;
    end else begin
      bus.o_msg_valid <= adv && last;
      bus.o_abort     <= mid_sync;
      if (bus.i_chip_valid) sr <= {sr[14:0], bus.i_chip};
      if (adv) begin
        sf_q <= sf_cur;
        acc  <= frame_start ? 5'd0 : a_fin;
        if (last) begin
          bus.o_msg_bit <= dec_bit;
          bus.o_corr    <= corr_w[5:0];
          bus.o_tie     <= dec_tie;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcsk_demodulator.sv
// Directed bench for dcsk_demodulator: hand-computed frames, abort, reset,
// and back-to-back SF32 frames with chip gaps.
module tb_dcsk_demodulator;
  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  dcsk_demodulator_if bus ();
  dcsk_demodulator dut (.i_clk(clk), .i_arst_n(arst_n), .bus(bus));

  int n_chk = 0, n_err = 0, pulses = 0;
  bit q_bit[$];
  int q_corr[$];

  always @(negedge clk)
    if (bus.o_msg_valid === 1'b1) begin
      pulses++;
      q_bit.push_back(bus.o_msg_bit);
      q_corr.push_back(int'($signed(bus.o_corr)));
    end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic c, input logic s, input logic [1:0] sf);
    bus.i_chip_valid = v;
    bus.i_chip       = c;
    bus.i_sync       = s;
    bus.i_sf         = sf;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_frame(input int h, input logic [15:0] r, input logic m);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < h; i++) begin
      f[i]     = r[i];
      f[i + h] = m ? r[i] : ~r[i];
    end
    return f;
  endfunction

  // Chip 0 carries the real SF; later chips carry junk SF when gaps are enabled.
  task automatic send_bits(input logic [1:0] sf, input logic [31:0] bits, input int n,
                           input logic sync0, input int gap_max);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat ($urandom_range(gap_max, 0)) drive(1'b0, 1'b0, 1'b0, 2'($urandom));
      drive(1'b1, bits[i], (i == 0) && sync0,
            (i == 0 || gap_max == 0) ? sf : 2'($urandom));
    end
  endtask

  task automatic check_dec(input string tag, input logic b, input int c, input logic t);
    chk({tag, ".valid"}, bus.o_msg_valid, 1);
    chk({tag, ".bit"}, bus.o_msg_bit, b);
    chk({tag, ".corr"}, $signed(bus.o_corr), c);
    chk({tag, ".tie"}, bus.o_tie, t);
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    chk({tag, ".pulse"}, bus.o_msg_valid, 0);
    chk({tag, ".hold"}, bus.o_msg_bit, b);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".bit"}, bus.o_msg_bit, 0);
    chk({tag, ".valid"}, bus.o_msg_valid, 0);
    chk({tag, ".corr"}, $signed(bus.o_corr), 0);
    chk({tag, ".tie"}, bus.o_tie, 0);
    chk({tag, ".abort"}, bus.o_abort, 0);
    chk({tag, ".busy"}, bus.o_busy, 0);
  endtask

  initial begin
    int p0;
    logic [15:0] r;
    logic m;
    logic exp_m[8];
    logic [31:0] f, old;

    arst_n = 1'b0;
    bus.i_chip_valid = 1'b0;
    bus.i_chip = 1'b0;
    bus.i_sync = 1'b0;
    bus.i_sf = 2'd0;
    #12;
    check_zero("reset");
    @(negedge clk) arst_n = 1'b1;

    // SF4: ref 1,0 / data 1,0 then ref 1,0 / data 0,1
    send_bits(2'd0, 32'b0101, 4, 1'b1, 0);
    check_dec("sf4_a", 1'b1, 2, 1'b0);
    send_bits(2'd0, 32'b1001, 4, 1'b1, 0);
    chk("sf4_b.abort", bus.o_abort, 0);
    check_dec("sf4_b", 1'b0, -2, 1'b0);

    // SF8 tie: ref 1,1,0,1 data 1,0,1,1 -> A=2
    send_bits(2'd1, 32'b11011011, 8, 1'b1, 0);
    check_dec("sf8_tie", 1'b1, 0, 1'b1);

    // SF32 extremes
    send_bits(2'd3, mk_frame(16, 16'hA5C3, 1'b0), 32, 1'b1, 0);
    check_dec("sf32_inv", 1'b0, -16, 1'b0);
    send_bits(2'd3, mk_frame(16, 16'hA5C3, 1'b1), 32, 1'b1, 0);
    check_dec("sf32_same", 1'b1, 16, 1'b0);

    // 8 back-to-back SF32 frames, gaps and mid-frame SF changes
    q_bit.delete();
    q_corr.delete();
    p0 = pulses;
    for (int fr = 0; fr < 8; fr++) begin
      r = 16'($urandom);
      m = 1'($urandom);
      exp_m[fr] = m;
      send_bits(2'd3, mk_frame(16, r, m), 32, fr == 0, 2);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    chk("rnd.count", pulses - p0, 8);
    for (int fr = 0; fr < 8; fr++) begin
      if (fr < q_bit.size()) begin
        chk($sformatf("rnd.bit%0d", fr), q_bit[fr], exp_m[fr]);
        chk($sformatf("rnd.corr%0d", fr), q_corr[fr], exp_m[fr] ? 16 : -16);
      end
    end

    // SF16 abort: sync on chip 10 restarts the frame
    p0 = pulses;
    old = mk_frame(8, 16'h0039, 1'b1);
    f = mk_frame(8, 16'h00C5, 1'b0);
    send_bits(2'd2, old, 10, 1'b1, 0);
    drive(1'b1, f[0], 1'b1, 2'd2);
    chk("abort.pulse", bus.o_abort, 1);
    chk("abort.novalid", bus.o_msg_valid, 0);
    for (int i = 1; i < 16; i++) begin
      drive(1'b1, f[i], 1'b0, 2'd2);
      if (i == 1) chk("abort.clear", bus.o_abort, 0);
    end
    check_dec("sf16_new", 1'b0, -8, 1'b0);
    chk("abort.pulses", pulses - p0, 1);

    // Reset during DATA of an SF8 frame
    send_bits(2'd1, mk_frame(4, 16'h000A, 1'b1), 8, 1'b1, 0);
    check_dec("sf8_pre", 1'b1, 4, 1'b0);
    send_bits(2'd1, mk_frame(4, 16'h0003, 1'b0), 6, 1'b1, 0);
    chk("rst.busy_before", bus.o_busy, 1);
    bus.i_chip_valid = 1'b0;
    #2 arst_n = 1'b0;
    #1 check_zero("rst_mid");
    p0 = pulses;
    repeat (2) @(posedge clk);
    @(negedge clk) arst_n = 1'b1;
    send_bits(2'd1, 32'h000000FF, 8, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 2'd1);
    chk("rst.nosync_busy", bus.o_busy, 0);
    chk("rst.nosync_pulses", pulses - p0, 0);
    send_bits(2'd1, mk_frame(4, 16'h0006, 1'b0), 8, 1'b1, 0);
    check_dec("sf8_post", 1'b0, -4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dcsk_demodulator.md
# dcsk_demodulator

Receive-side counterpart of the DCSK transmit chain. Takes the serial binary chip stream, buffers the reference (chaos) half of each frame, correlates it chip-by-chip against the information half, and emits one decided message bit per frame with its correlation value. Sits after chip recovery/frame sync in the RX path and feeds the message-bit consumer.

## Interface
Parameters: none. Spreading factors come from `spreading_factors_pkg` (SF4, SF8, SF16, SF32 on the 2-bit `i_sf`).

Ports:
- `i_clk` in 1: clock.
- `i_arst_n` in 1: reset, asynchronous, active-low.
- `i_chip` in 1: received chip, sampled when `i_chip_valid`=1.
- `i_chip_valid` in 1: chip qualifier; no state advances when 0.
- `i_sync` in 1: marks the current valid chip as chip 0 of a frame; ignored unless `i_chip_valid`=1.
- `i_sf` in 2: spreading factor, sampled only on a frame's chip 0.
- `o_msg_bit` out 1: decided bit of the last completed frame.
- `o_msg_valid` out 1: one-cycle pulse, new decision.
- `o_corr` out 6, signed: correlation 2A−H of the last frame (range −16..+16).
- `o_tie` out 1: last decision was a tie (A = H/2).
- `o_abort` out 1: one-cycle pulse, frame discarded by a mid-frame `i_sync`.
- `o_busy` out 1: 1 in REF or DATA state.

## Operation
- SF = 4/8/16/32 chips per frame; H = SF/2. Chips 0..H−1 are the reference, chips H..SF−1 are the data half. Tx rule: data chip k = ref chip k XNOR msg (msg=1 copies, msg=0 inverts).
- 16-bit chip shift register, shifted on every valid chip. Delayed reference = tap H−1 (SF4→1, SF8→3, SF16→7, SF32→15), i.e. the chip H positions earlier.
- Agreement counter A (5 bits, 0..16): cleared at chip 0; incremented when a data-half chip equals the delayed reference.
- Decision at the last chip (SF−1): A > H/2 → 1; A < H/2 → 0; A = H/2 → 1 with `o_tie`=1. `o_corr` = 2A−H, sign-extended to 6 bits.
- The chip counter is 5 bits, 0..SF−1. The latched SF is held for the whole frame. Changes on `i_sf` mid-frame have no effect.
- FSM:
  - IDLE: wait for valid chip with `i_sync`=1. That chip is chip 0: latch SF, go to REF.
  - REF: collect chips 1..H−1, then go to DATA.
  - DATA: correlate chips H..SF−1. After the last chip, publish the decision. The next valid chip is chip 0 of the following frame (back-to-back), so go to REF and latch SF again. The FSM never returns to IDLE except by reset.
  - `i_sync` on a valid chip in REF or DATA at counter ≠ 0: pulse `o_abort`, drop the partial frame (no `o_msg_valid`), and treat that chip as chip 0 of a new frame. `i_sync` on the expected chip 0 is a normal resync: no abort.
- Invalid `i_chip_valid` gaps of any length are allowed inside a frame. The counter, A, and the shift register hold.

## Timing
- Reset: state IDLE, counter 0, A 0, shift register 0, `o_msg_bit`=0, `o_msg_valid`=0, `o_corr`=0, `o_tie`=0, `o_abort`=0, `o_busy`=0.
- Reset mid-frame clears everything, with no output pulse. After release, wait for `i_sync`.
- Latency: last chip accepted at edge t → `o_msg_valid`, `o_msg_bit`, `o_corr`, `o_tie` updated at edge t+1. `o_msg_valid` is high for exactly one cycle. The other three hold until the next decision.
- `o_abort`: registered, high the cycle after the offending chip.
- Throughput: one chip per cycle sustained, with no bubble between frames.

## Test plan
- SF4, sync, chips 1,0,1,0 → `o_msg_valid` one cycle after chip 3, `o_msg_bit`=1, `o_corr`=+2, `o_tie`=0. Chips 1,0,0,1 → bit 0, `o_corr`=−2.
- SF8, ref 1,1,0,1, data 1,0,1,1 (A=2) → bit 1, `o_tie`=1, `o_corr`=0.
- SF32: 8 back-to-back frames from a random chaos stream and random message bits, with random `i_chip_valid` gaps and `i_sf` toggled mid-frame → all 8 bits match, one `o_msg_valid` per frame, no lost chip between frames.
- SF16, `i_sync` on chip 10 → `o_abort` pulse, no `o_msg_valid`. The new frame starting at that chip decodes correctly 16 chips later.
- `i_arst_n` asserted during DATA of an SF8 frame → all outputs 0, no pulse. Chips without `i_sync` after release → no output. Sync plus a full frame → correct decision.
- Max-noise SF32: data half fully inverted versus the reference → bit 0, `o_corr`=−16. Data half identical to the reference → `o_corr`=+16.
